// File: rtl/sort_seq.sv
// In-place selection sort of RAM words 0..N-1 through a single-port synchronous RAM.
// Outputs are registered one state ahead so each RAM address is presented during its own state.
module sort_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          done,
  output logic [7:0]    swaps,
  output logic [2:0]    PS
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_I     = 3'd1,
    LAT_I    = 3'd2,
    SCAN_RD  = 3'd3,
    SCAN_CMP = 3'd4,
    SW1      = 3'd5,
    SW2      = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state;
  logic [AW-1:0] i, j, min_idx;
  logic [DW-1:0] min_val, anchor_val;

  logic [AW-1:0] i_inc, j_inc, scan_idx;
  logic [DW-1:0] scan_val;

  // Running minimum including the word returned this cycle; ties keep the earlier index.
  always_comb begin
    i_inc    = i + AW'(1);
    j_inc    = j + AW'(1);
    scan_idx = min_idx;
    scan_val = min_val;
    if (ram_rdata < min_val) begin
      scan_idx = j;
      scan_val = ram_rdata;
    end
  end

  // RD_I reads the anchor only when it is not the final index.
  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] ni);
    return (ni == LAST) ? '0 : ni;
  endfunction

  assign PS = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      min_idx    <= '0;
      min_val    <= '0;
      anchor_val <= '0;
      swaps      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      done      <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            i        <= '0;
            swaps    <= '0;
            state    <= RD_I;
            busy     <= 1'b1;
            ram_addr <= rd_addr('0);
          end
        end
        RD_I: begin
          if (i == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= LAT_I;
          end
        end
        LAT_I: begin
          anchor_val <= ram_rdata;
          min_val    <= ram_rdata;
          min_idx    <= i;
          j          <= i_inc;
          state      <= SCAN_RD;
          ram_addr   <= i_inc;
        end
        SCAN_RD: state <= SCAN_CMP;
        SCAN_CMP: begin
          min_val <= scan_val;
          min_idx <= scan_idx;
          if (j == LAST) begin
            if (scan_idx != i) begin
              state     <= SW1;
              ram_we    <= 1'b1;
              ram_addr  <= i;
              ram_wdata <= scan_val;
            end else begin
              i        <= i_inc;
              state    <= RD_I;
              ram_addr <= rd_addr(i_inc);
            end
          end else begin
            j        <= j_inc;
            state    <= SCAN_RD;
            ram_addr <= j_inc;
          end
        end
        SW1: begin
          state     <= SW2;
          ram_we    <= 1'b1;
          ram_addr  <= min_idx;
          ram_wdata <= anchor_val;
        end
        SW2: begin
          if (swaps != 8'hFF) swaps <= swaps + 8'd1;
          i        <= i_inc;
          state    <= RD_I;
          ram_addr <= rd_addr(i_inc);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq.sv
// Directed bench for sort_seq: an N=8 instance on a modelled synchronous RAM and an N=1 instance.
module tb_sort_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy, done;
  logic [7:0] swaps;
  logic [2:0] ps;

  logic       start1;
  logic [0:0] addr1;
  logic       we1;
  logic [7:0] wdata1;
  logic       busy1, done1;
  logic [7:0] swaps1;
  logic [2:0] ps1;

  always #5 clk = ~clk;

  sort_seq #(.N(8), .DW(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_addr(addr), .ram_we(we),
    .ram_wdata(wdata), .ram_rdata(rdata), .busy(busy), .done(done),
    .swaps(swaps), .PS(ps)
  );

  sort_seq #(.N(1), .DW(8), .AW(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ram_addr(addr1), .ram_we(we1),
    .ram_wdata(wdata1), .ram_rdata(8'd0), .busy(busy1), .done(done1),
    .swaps(swaps1), .PS(ps1)
  );

  // RAM model plus cumulative activity monitors.
  logic [7:0] mem [8];
  logic [7:0] ld_vec [8];
  logic       ld = 1'b0;
  int         we_cnt = 0, done_cnt = 0, we1_cnt = 0, addr1_cnt = 0;
  logic [2:0] wr_a [$];
  logic [7:0] wr_d [$];

  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < 8; k++) mem[k] <= ld_vec[k];
    end else if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
    if (we) begin
      we_cnt <= we_cnt + 1;
      wr_a.push_back(addr);
      wr_d.push_back(wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (we1) we1_cnt <= we1_cnt + 1;
    if (addr1 != 1'b0) addr1_cnt <= addr1_cnt + 1;
  end

  int chk = 0, pass = 0;
  logic [7:0] vec [8];
  logic [7:0] sorted_exp [8];

  task automatic load(input logic [7:0] v [8]);
    @(negedge clk);
    ld_vec = v;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 500; n++) begin
      @(negedge clk);
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic check_mem(input string name, input logic [7:0] e [8]);
    int bad = 0;
    for (int k = 0; k < 8; k++) if (mem[k] !== e[k]) bad++;
    chk++;
    if (bad != 0) $display("FAIL %s: %0d words differ, mem[0]=%0d mem[7]=%0d", name, bad, mem[0], mem[7]);
    else pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk++; if (ps !== 3'd0) $display("FAIL reset_ps: got %0d want 0", ps); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
    chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass++;
    chk++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else pass++;
    chk++; if (addr !== 3'd0) $display("FAIL reset_addr: got %0d want 0", addr); else pass++;
    chk++; if (wdata !== 8'd0) $display("FAIL reset_wdata: got %0d want 0", wdata); else pass++;
    chk++; if (swaps !== 8'd0) $display("FAIL reset_swaps: got %0d want 0", swaps); else pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sorted();
    int cyc, we0;
    vec = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load(vec);
    we0 = we_cnt;
    pulse_start();
    wait_done(cyc);
    chk++; if (cyc !== 72) $display("FAIL sorted_latency: got %0d want 72", cyc); else pass++;
    chk++; if (swaps !== 8'd0) $display("FAIL sorted_swaps: got %0d want 0", swaps); else pass++;
    @(negedge clk);
    chk++; if (we_cnt - we0 !== 0) $display("FAIL sorted_writes: got %0d want 0", we_cnt - we0); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL sorted_idle_busy: got %b want 0", busy); else pass++;
    check_mem("sorted_mem", sorted_exp);
  endtask

  task automatic test_reverse();
    int cyc;
    vec = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    load(vec);
    pulse_start();
    wait_done(cyc);
    chk++; if (cyc !== 80) $display("FAIL reverse_latency: got %0d want 80", cyc); else pass++;
    chk++; if (swaps !== 8'd4) $display("FAIL reverse_swaps: got %0d want 4", swaps); else pass++;
    chk++; if (done_cnt < 1 || ps !== 3'd7) $display("FAIL reverse_done_state: got %0d want 7", ps); else pass++;
    @(negedge clk);
    check_mem("reverse_mem", sorted_exp);
  endtask

  task automatic test_duplicates();
    int cyc, base;
    logic [7:0] ea [8];
    logic [7:0] ed [8];
    logic [7:0] em [8];
    int bad;
    ea = '{8'd0, 8'd6, 8'd1, 8'd7, 8'd2, 8'd3, 8'd3, 8'd7};
    ed = '{8'd0, 8'd3, 8'd0, 8'd1, 8'd1, 8'd3, 8'd1, 8'd3};
    em = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    vec = '{8'd3, 8'd1, 8'd3, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
    load(vec);
    base = wr_a.size();
    pulse_start();
    wait_done(cyc);
    chk++; if (cyc !== 80) $display("FAIL dup_latency: got %0d want 80", cyc); else pass++;
    chk++; if (swaps !== 8'd4) $display("FAIL dup_swaps: got %0d want 4", swaps); else pass++;
    @(negedge clk);
    chk++;
    if (wr_a.size() - base !== 8) begin
      $display("FAIL dup_write_count: got %0d want 8", wr_a.size() - base);
    end else begin
      bad = 0;
      for (int k = 0; k < 8; k++) if (wr_a[base+k] !== ea[k] || wr_d[base+k] !== ed[k]) bad++;
      if (bad != 0) $display("FAIL dup_write_order: %0d writes wrong, first addr %0d data %0d", bad, wr_a[base], wr_d[base]);
      else pass++;
    end
    check_mem("dup_mem", em);
  endtask

  task automatic test_reset_in_sw1();
    int cyc, base, seen;
    vec = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    load(vec);
    base = we_cnt;
    pulse_start();
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ps == 3'd5) begin
        seen = 1;
        break;
      end
    end
    chk++; if (seen != 1) $display("FAIL abort_reach_sw1: got %0d want 1", seen); else pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk++; if (ps !== 3'd0) $display("FAIL abort_ps: got %0d want 0", ps); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass++;
    chk++; if (we !== 1'b0) $display("FAIL abort_we: got %b want 0", we); else pass++;
    chk++; if (swaps !== 8'd0) $display("FAIL abort_swaps: got %0d want 0", swaps); else pass++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk++; if (we_cnt - base !== 1) $display("FAIL abort_writes: got %0d want 1", we_cnt - base); else pass++;
    vec = '{8'd5, 8'd2, 8'd7, 8'd1, 8'd0, 8'd6, 8'd3, 8'd4};
    load(vec);
    pulse_start();
    wait_done(cyc);
    chk++; if (cyc !== 86) $display("FAIL rerun_latency: got %0d want 86", cyc); else pass++;
    chk++; if (swaps !== 8'd7) $display("FAIL rerun_swaps: got %0d want 7", swaps); else pass++;
    @(negedge clk);
    check_mem("rerun_mem", sorted_exp);
  endtask

  task automatic test_start_held();
    int cyc, d0;
    vec = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load(vec);
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    wait_done(cyc);
    chk++; if (cyc !== 72) $display("FAIL held_latency: got %0d want 72", cyc); else pass++;
    @(negedge clk);
    chk++; if (done_cnt - d0 !== 1) $display("FAIL held_done_count: got %0d want 1", done_cnt - d0); else pass++;
    chk++; if (ps !== 3'd0 || busy !== 1'b0) $display("FAIL held_idle: got ps %0d busy %b want 0 0", ps, busy); else pass++;
    @(negedge clk);
    chk++; if (ps !== 3'd1 || busy !== 1'b1) $display("FAIL held_restart: got ps %0d busy %b want 1 1", ps, busy); else pass++;
    start = 1'b0;
    wait_done(cyc);
    chk++; if (cyc !== 71) $display("FAIL held_second_latency: got %0d want 71", cyc); else pass++;
    @(negedge clk);
  endtask

  task automatic test_n1();
    int cyc, w0, a0;
    w0 = we1_cnt;
    a0 = addr1_cnt;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk++; if (ps1 !== 3'd1 || busy1 !== 1'b1) $display("FAIL n1_rd_i: got ps %0d busy %b want 1 1", ps1, busy1); else pass++;
      end
      if (done1) begin
        cyc = n;
        break;
      end
    end
    chk++; if (cyc !== 2) $display("FAIL n1_latency: got %0d want 2", cyc); else pass++;
    @(negedge clk);
    chk++; if (ps1 !== 3'd0 || done1 !== 1'b0) $display("FAIL n1_idle: got ps %0d done %b want 0 0", ps1, done1); else pass++;
    chk++; if (we1_cnt - w0 !== 0 || addr1_cnt - a0 !== 0) $display("FAIL n1_no_ram: got writes %0d addrs %0d want 0 0", we1_cnt - w0, addr1_cnt - a0); else pass++;
    chk++; if (swaps1 !== 8'd0) $display("FAIL n1_swaps: got %0d want 0", swaps1); else pass++;
  endtask

  initial begin
    sorted_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    test_reset();
    test_sorted();
    test_reverse();
    test_duplicates();
    test_reset_in_sw1();
    test_start_held();
    test_n1();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/sort_seq.md
SORT_SEQ -- requirements
Module: sort_seq

Interface
REQ-001 Parameter N, default 8: array length; legal range 1..256.
REQ-002 Parameter DW, default 8: element width in bits.
REQ-003 Parameter AW, default 3: RAM address width; SHALL satisfy 2^AW >= N.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset; synchronous and active-low (rst==0 at a rising edge resets the block).
REQ-006 Port start, input, 1: begin sort of RAM words 0..N-1; sampled only in IDLE.
REQ-007 Port ram_addr, output, AW: address to the single-port array RAM.
REQ-008 Port ram_we, output, 1: RAM write enable.
REQ-009 Port ram_wdata, output, DW: RAM write data.
REQ-010 Port ram_rdata, input, DW: RAM read data; valid one cycle after ram_addr is presented with ram_we=0.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port done, output, 1: one-cycle pulse on sort completion.
REQ-013 Port swaps, output, 8: count of swaps performed in the current or last sort; saturates at 255.
REQ-014 Port PS, output, 3: present-state code for debug.

Function
REQ-015 The FSM SHALL use these states and codes: IDLE=0, RD_I=1, LAT_I=2, SCAN_RD=3, SCAN_CMP=4, SW1=5, SW2=6, DONE=7.
REQ-016 Internal registers SHALL be: i, j, min_idx (AW bits each); min_val and anchor_val (DW bits each).
REQ-017 IDLE: if start==1, SHALL set i=0, clear swaps and go to RD_I; otherwise stay in IDLE.
REQ-018 RD_I: if i==N-1, SHALL go to DONE; otherwise drive ram_addr=i and go to LAT_I.
REQ-019 LAT_I: SHALL load anchor_val=min_val=ram_rdata, min_idx=i and j=i+1, then go to SCAN_RD.
REQ-020 SCAN_RD: SHALL drive ram_addr=j and go to SCAN_CMP.
REQ-021 SCAN_CMP, update rule: if ram_rdata < min_val (unsigned, strict), SHALL set min_val=ram_rdata and min_idx=j; ties keep the earlier index.
REQ-022 SCAN_CMP, exit rule: if j==N-1, SHALL go to SW1 when min_idx (including any update made this cycle) != i; otherwise increment i and go to RD_I.
REQ-023 SCAN_CMP, continue rule: if j!=N-1, SHALL increment j and go to SCAN_RD.
REQ-024 SW1: SHALL drive ram_we=1, ram_addr=i, ram_wdata=min_val, and go to SW2.
REQ-025 SW2: SHALL drive ram_we=1, ram_addr=min_idx, ram_wdata=anchor_val, increment swaps (saturating), increment i, and go to RD_I.
REQ-026 DONE: SHALL assert done=1 for exactly this one cycle, then go to IDLE.
REQ-027 ram_we SHALL be 1 only in SW1 and SW2.
REQ-028 In states where the RAM is not addressed, ram_addr and ram_wdata SHALL be 0.
REQ-029 start asserted while busy==1 SHALL be ignored, with no effect on state or registers.
REQ-030 With N==1, a sort SHALL take the path IDLE->RD_I->DONE and perform no RAM access.
REQ-031 Counters SHALL never address beyond N-1.
REQ-032 Timing: each anchor SHALL cost 2 + 2*(N-1-i) cycles, plus 2 cycles if a swap occurs.

Reset
REQ-033 On rst==0 at a rising edge, from any state, the block SHALL enter IDLE.
REQ-034 On that reset, i, j, min_idx, min_val, anchor_val and swaps SHALL be cleared.
REQ-035 From the first cycle after the reset edge: busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, PS=0.
REQ-036 Reset during SW1 or SW2 SHALL abort without issuing any further write; the RAM contents are then undefined for the sort.

Verification
REQ-037 RAM {0,1,2,3,4,5,6,7}, N=8, start pulse -> done high 72 clocks after the start-sampling edge; swaps=0; ram_we never high.
REQ-038 RAM {7,6,5,4,3,2,1,0} -> RAM sorted ascending; swaps=4; done 80 clocks after the start edge.
REQ-039 RAM {3,1,3,1,2,2,0,0} -> RAM {0,0,1,1,2,2,3,3}; each swap writes address i first, then min_idx; min_idx is the first occurrence on ties.
REQ-040 rst=0 asserted in SW1 on the first swap -> next cycle PS=0, busy=0, ram_we=0, swaps=0; a later start runs a full sort correctly.
REQ-041 start held high for the whole sort -> exactly one sort and one done pulse, then a new sort starts from IDLE.
REQ-042 N=1 -> done pulse 2 clocks after the start edge; no RAM reads or writes.
